// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-port arbiter in front of the 1024x8 main_memory.
// Port 0 is the CPU load/store path, port 1 the program loader/debug port.
// Single-byte reads/writes from either port are serialised onto the single
// memory port. Read data comes back one cycle after issue, because the memory
// output is registered.
//
// Handshake: a requester raises reqX with weX/addrX/wdataX stable. The grant
// pulse gntX is the "ready": on the clock edge that samples gntX=1 the
// requester drops reqX or presents its next transaction. A reqX still high in
// the cycle after gntX is treated as a new request. A read completes with a
// one-cycle rvalidX pulse; rdataX holds its value until the next read on
// that port.
module ram_port_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic              clock,
    input  logic              rst_n,
    // port 0
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    // port 1
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              prio_q, prio_d;    // port that wins the next contested grant
    logic              owner_q, owner_d;  // port whose transaction is in flight

    logic              gnt0_d, gnt1_d;
    logic              rvalid0_d, rvalid1_d;
    logic [DATA_W-1:0] rdata0_d, rdata1_d;
    logic              mem_en_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    logic              contested;
    logic              winner;

    // Winner selection: a lone requester always wins; a tie goes to prio in
    // round-robin mode, otherwise to port 0.
    always_comb begin
        contested = req0 & req1;
        winner    = 1'b0;
        if (contested) begin
            winner = (ROUND_ROBIN != 1'b0) ? prio_q : 1'b0;
        end else begin
            winner = req1;
        end
    end

    // Next-state and next-output logic; strobes default low, data holds.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0;
        rdata1_d    = rdata1;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    owner_d  = winner;
                    mem_en_d = 1'b1;
                    // prio only moves when there was actually a contest
                    if (contested && (ROUND_ROBIN != 1'b0)) begin
                        prio_d = ~winner;
                    end
                    if (winner) begin
                        gnt1_d      = 1'b1;
                        mem_we_d    = we1;
                        mem_addr_d  = addr1;
                        mem_wdata_d = wdata1;
                    end else begin
                        gnt0_d      = 1'b1;
                        mem_we_d    = we0;
                        mem_addr_d  = addr0;
                        mem_wdata_d = wdata0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // memory executes the access at the edge closing this cycle;
                // mem_we still reflects the access being issued
                state_d = mem_we ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                // registered memory output is valid during this cycle
                if (owner_q) begin
                    rvalid1_d = 1'b1;
                    rdata1_d  = mem_rdata;
                end else begin
                    rvalid0_d = 1'b1;
                    rdata0_d  = mem_rdata;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset also drops any in-flight read.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            owner_q   <= owner_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            rvalid0   <= rvalid0_d;
            rvalid1   <= rvalid1_d;
            rdata0    <= rdata0_d;
            rdata1    <= rdata1_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter. Instance 0 is round-robin, instance 1 is fixed
// priority; each has its own memory model and its own transaction-level
// reference model.
module tb_ram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic rst_n;

    // ---------------- DUT signals (index = instance) ----------------
    logic          req0_i[2], we0_i[2], req1_i[2], we1_i[2];
    logic [AW-1:0] addr0_i[2], addr1_i[2];
    logic [DW-1:0] wdata0_i[2], wdata1_i[2], mem_rdata_i[2];
    logic          gnt0_o[2], gnt1_o[2], rvalid0_o[2], rvalid1_o[2];
    logic [DW-1:0] rdata0_o[2], rdata1_o[2], mem_wdata_o[2];
    logic          mem_en_o[2], mem_we_o[2], busy_o[2];
    logic [AW-1:0] mem_addr_o[2];
    logic [1:0]    dbg_o[2];

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1'b1)) u_rr (
        .clock(clock), .rst_n(rst_n),
        .req0(req0_i[0]), .we0(we0_i[0]), .addr0(addr0_i[0]), .wdata0(wdata0_i[0]),
        .gnt0(gnt0_o[0]), .rvalid0(rvalid0_o[0]), .rdata0(rdata0_o[0]),
        .req1(req1_i[0]), .we1(we1_i[0]), .addr1(addr1_i[0]), .wdata1(wdata1_i[0]),
        .gnt1(gnt1_o[0]), .rvalid1(rvalid1_o[0]), .rdata1(rdata1_o[0]),
        .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
        .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata_i[0]),
        .busy(busy_o[0]), .dbg_state(dbg_o[0])
    );

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1'b0)) u_fp (
        .clock(clock), .rst_n(rst_n),
        .req0(req0_i[1]), .we0(we0_i[1]), .addr0(addr0_i[1]), .wdata0(wdata0_i[1]),
        .gnt0(gnt0_o[1]), .rvalid0(rvalid0_o[1]), .rdata0(rdata0_o[1]),
        .req1(req1_i[1]), .we1(we1_i[1]), .addr1(addr1_i[1]), .wdata1(wdata1_i[1]),
        .gnt1(gnt1_o[1]), .rvalid1(rvalid1_o[1]), .rdata1(rdata1_o[1]),
        .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
        .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata_i[1]),
        .busy(busy_o[1]), .dbg_state(dbg_o[1])
    );

    // ---------------- main_memory models (registered read) ----------------
    bit [DW-1:0] dmem[2][1024];
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_en_o[k] === 1'b1) begin
                if (mem_we_o[k]) dmem[k][mem_addr_o[k]] <= mem_wdata_o[k];
                else             mem_rdata_i[k]        <= dmem[k][mem_addr_o[k]];
            end
        end
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h",
                         name, k, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Per-cycle expectation ring indexed by cycle % 8; arbitration decisions
    // are made at transaction level: when the arbiter is free, the pending
    // request(s) produce a grant next cycle and, for reads, data three
    // cycles after the request.
    bit            e_gnt0[2][8], e_gnt1[2][8], e_en[2][8], e_we[2][8];
    bit            e_rv0[2][8], e_rv1[2][8];
    logic [AW-1:0] e_addr[2][8];
    logic [DW-1:0] e_wd[2][8], e_rd[2][8];
    logic [AW-1:0] h_addr[2];
    logic [DW-1:0] h_wd[2], h_rd0[2], h_rd1[2];
    int            next_free[2];
    bit            rr_prio[2];
    bit [DW-1:0]   ref_mem[2][1024];

    // observations for hand-computed checks
    bit gq_rr[$];
    bit gq_fp[$];
    int en_cyc_q[$];
    int rv_cnt0 = 0;
    logic [0:0] exp_q[$];

    task automatic model_reset(input int k);
        for (int s = 0; s < 8; s++) begin
            e_gnt0[k][s] = 0; e_gnt1[k][s] = 0; e_en[k][s] = 0; e_we[k][s] = 0;
            e_rv0[k][s]  = 0; e_rv1[k][s]  = 0;
        end
        h_addr[k] = '0; h_wd[k] = '0; h_rd0[k] = '0; h_rd1[k] = '0;
        next_free[k] = 0;
        rr_prio[k]   = 0;
    endtask

    task automatic check_cycle(input int k);
        int s = cyc % 8;
        if (e_en[k][s]) begin h_addr[k] = e_addr[k][s]; h_wd[k] = e_wd[k][s]; end
        if (e_rv0[k][s]) h_rd0[k] = e_rd[k][s];
        if (e_rv1[k][s]) h_rd1[k] = e_rd[k][s];
        chk("gnt0",      k, 32'(gnt0_o[k]),    32'(e_gnt0[k][s]));
        chk("gnt1",      k, 32'(gnt1_o[k]),    32'(e_gnt1[k][s]));
        chk("mem_en",    k, 32'(mem_en_o[k]),  32'(e_en[k][s]));
        chk("mem_we",    k, 32'(mem_we_o[k]),  32'(e_we[k][s]));
        chk("mem_addr",  k, 32'(mem_addr_o[k]), 32'(h_addr[k]));
        chk("mem_wdata", k, 32'(mem_wdata_o[k]), 32'(h_wd[k]));
        chk("rvalid0",   k, 32'(rvalid0_o[k]), 32'(e_rv0[k][s]));
        chk("rvalid1",   k, 32'(rvalid1_o[k]), 32'(e_rv1[k][s]));
        chk("rdata0",    k, 32'(rdata0_o[k]),  32'(h_rd0[k]));
        chk("rdata1",    k, 32'(rdata1_o[k]),  32'(h_rd1[k]));
        chk("busy",      k, 32'(busy_o[k]),    32'(cyc < next_free[k]));
        e_gnt0[k][s] = 0; e_gnt1[k][s] = 0; e_en[k][s] = 0; e_we[k][s] = 0;
        e_rv0[k][s]  = 0; e_rv1[k][s]  = 0;
    endtask

    task automatic arbitrate(input int k);
        bit r0 = (req0_i[k] === 1'b1);
        bit r1 = (req1_i[k] === 1'b1);
        bit win, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int s1, s3;
        if (cyc >= next_free[k] && (r0 || r1)) begin
            if (r0 && r1) begin
                if (k == 0) begin
                    win = rr_prio[k];
                    rr_prio[k] = !win;
                end else begin
                    win = 0;
                end
            end else begin
                win = r1;
            end
            we = win ? we1_i[k]    : we0_i[k];
            a  = win ? addr1_i[k]  : addr0_i[k];
            d  = win ? wdata1_i[k] : wdata0_i[k];
            s1 = (cyc + 1) % 8;
            e_en[k][s1] = 1; e_we[k][s1] = we; e_addr[k][s1] = a; e_wd[k][s1] = d;
            if (win) e_gnt1[k][s1] = 1; else e_gnt0[k][s1] = 1;
            if (we) begin
                ref_mem[k][a] = d;
                next_free[k]  = cyc + 2;
            end else begin
                s3 = (cyc + 3) % 8;
                e_rd[k][s3] = ref_mem[k][a];
                if (win) e_rv1[k][s3] = 1; else e_rv0[k][s3] = 1;
                next_free[k] = cyc + 3;
            end
        end
    endtask

    // Compare process: checks every cycle out of reset, away from the edge.
    always @(negedge clock) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                model_reset(k);
            end else begin
                check_cycle(k);
                if (k == 0) begin
                    if (gnt0_o[0] === 1'b1) gq_rr.push_back(1'b0);
                    if (gnt1_o[0] === 1'b1) gq_rr.push_back(1'b1);
                    if (mem_en_o[0] === 1'b1) en_cyc_q.push_back(cyc);
                    if (rvalid0_o[0] === 1'b1) rv_cnt0++;
                end else begin
                    if (gnt0_o[1] === 1'b1) gq_fp.push_back(1'b0);
                    if (gnt1_o[1] === 1'b1) gq_fp.push_back(1'b1);
                end
                arbitrate(k);
            end
        end
    end

    // ---------------- driver tasks (called #1 after a rising edge) ----------------
    task automatic set_req(input int k, input int p, input bit r, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin req0_i[k] = r; we0_i[k] = we; addr0_i[k] = a; wdata0_i[k] = d; end
        else        begin req1_i[k] = r; we1_i[k] = we; addr1_i[k] = a; wdata1_i[k] = d; end
    endtask

    task automatic drive(input int k, input int p, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
        bit seen = 0;
        set_req(k, p, 1'b1, we, a, d);
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            seen = (p == 0) ? (gnt0_o[k] === 1'b1) : (gnt1_o[k] === 1'b1);
        end
        chk("gnt_timeout", k, 32'(seen), 32'd1);
        @(posedge clock); #1;
        if (!hold || !seen) begin
            if (p == 0) req0_i[k] = 1'b0; else req1_i[k] = 1'b0;
        end
    endtask

    // Read on instance 0 counting negedges from the request cycle (1 = request cycle).
    task automatic lat_read(input int p, input logic [AW-1:0] a,
                            output int gl, output int rl, output logic [DW-1:0] dat);
        gl = -1; rl = -1; dat = '0;
        set_req(0, p, 1'b1, 1'b0, a, '0);
        for (int n = 1; n <= 20 && rl < 0; n++) begin
            @(negedge clock);
            if (gl < 0 && ((p == 0) ? gnt0_o[0] : gnt1_o[0]) === 1'b1) begin
                gl = n;
                @(posedge clock); #1;
                if (p == 0) req0_i[0] = 1'b0; else req1_i[0] = 1'b0;
            end else if (((p == 0) ? rvalid0_o[0] : rvalid1_o[0]) === 1'b1) begin
                rl  = n;
                dat = (p == 0) ? rdata0_o[0] : rdata1_o[0];
            end
        end
        if (p == 0) req0_i[0] = 1'b0; else req1_i[0] = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic rand_traffic(input int k, input int p, input int n);
        bit prev_hold = 0;
        bit hold, we;
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            if (!prev_hold) begin
                int gap = $urandom_range(0, 3);
                repeat (gap) @(posedge clock);
                if (gap > 0) #1;
            end
            we   = 1'($urandom_range(0, 1));
            a    = 10'($urandom_range(0, 15)) + 10'h3F8;
            hold = ($urandom_range(0, 3) == 0) && (i < n - 1);
            drive(k, p, we, a, 8'($urandom), hold);
            prev_hold = hold;
        end
    endtask

    task automatic chk_zero(input string name, input int k);
        chk({name, "_gnt0"},   k, 32'(gnt0_o[k]),    0);
        chk({name, "_gnt1"},   k, 32'(gnt1_o[k]),    0);
        chk({name, "_rvalid"}, k, {30'd0, rvalid1_o[k], rvalid0_o[k]}, 0);
        chk({name, "_rdata"},  k, {16'd0, rdata1_o[k], rdata0_o[k]}, 0);
        chk({name, "_mem_en"}, k, {30'd0, mem_en_o[k], mem_we_o[k]}, 0);
        chk({name, "_mem_aw"}, k, {14'd0, mem_addr_o[k], mem_wdata_o[k]}, 0);
        chk({name, "_busy"},   k, 32'(busy_o[k]),    0);
    endtask

    // ---------------- stimulus sequence ----------------
    initial begin
        int gl, rl, n, rv_before;
        bit seen;
        logic [DW-1:0] dat;

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_req(k, 0, 1'b0, 1'b0, '0, '0);
            set_req(k, 1, 1'b0, 1'b0, '0, '0);
        end
        repeat (3) @(posedge clock);
        #1;
        chk_zero("reset", 0);
        chk_zero("reset", 1);
        rst_n = 1'b1;

        // port 0 write 0x155 = 0xA5, then read it back
        drive(0, 0, 1'b1, 10'h155, 8'hA5, 1'b0);
        lat_read(0, 10'h155, gl, rl, dat);
        chk("rd_gnt_lat",    0, gl, 2);
        chk("rd_rvalid_lat", 0, rl, 4);
        chk("rd_data_155",   0, 32'(dat), 32'hA5);

        // port 1 back-to-back writes at the wrap boundary, then read back
        n = en_cyc_q.size();
        drive(0, 1, 1'b1, 10'h3FF, 8'h11, 1'b1);
        drive(0, 1, 1'b1, 10'h000, 8'h22, 1'b0);
        chk("b2b_count", 0, en_cyc_q.size() - n, 2);
        if (en_cyc_q.size() >= n + 2)
            chk("b2b_gap", 0, en_cyc_q[n+1] - en_cyc_q[n], 2);
        lat_read(1, 10'h3FF, gl, rl, dat);
        chk("rd_data_3ff", 0, 32'(dat), 32'h11);
        lat_read(1, 10'h000, gl, rl, dat);
        chk("rd_data_000", 0, 32'(dat), 32'h22);

        // round-robin contention, reads held back-to-back on both ports
        n = gq_rr.size();
        fork
            begin drive(0, 0, 1'b0, 10'h3FF, 8'h00, 1'b1); drive(0, 0, 1'b0, 10'h000, 8'h00, 1'b0); end
            begin drive(0, 1, 1'b0, 10'h155, 8'h00, 1'b1); drive(0, 1, 1'b0, 10'h3FF, 8'h00, 1'b0); end
        join
        repeat (4) @(posedge clock); #1;
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++)
            chk("rr_order", 0, (gq_rr.size() > n + i) ? 32'(gq_rr[n+i]) : 32'hFFFF, 32'(exp_q[i]));

        // fixed priority: port 0 wins four times, port 1 only after port 0 drops
        n = gq_fp.size();
        fork
            begin
                drive(1, 0, 1'b0, 10'h001, 8'h00, 1'b1);
                drive(1, 0, 1'b0, 10'h002, 8'h00, 1'b1);
                drive(1, 0, 1'b0, 10'h003, 8'h00, 1'b1);
                drive(1, 0, 1'b0, 10'h004, 8'h00, 1'b0);
            end
            drive(1, 1, 1'b0, 10'h3FF, 8'h00, 1'b0);
        join
        repeat (4) @(posedge clock); #1;
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++)
            chk("fp_order", 1, (gq_fp.size() > n + i) ? 32'(gq_fp[n+i]) : 32'hFFFF, 32'(exp_q[i]));

        // held request: req1 still high the cycle after gnt1 -> second grant
        n = gq_rr.size();
        drive(0, 1, 1'b1, 10'h010, 8'h33, 1'b1);
        drive(0, 1, 1'b1, 10'h010, 8'h33, 1'b0);
        repeat (2) @(posedge clock); #1;
        chk("held_gnt_count", 0, gq_rr.size() - n, 2);

        // reset while a port 0 read is in ISSUE
        set_req(0, 0, 1'b1, 1'b0, 10'h155, '0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = (gnt0_o[0] === 1'b1);
        end
        chk("rst_gnt_seen", 0, 32'(seen), 1);
        #2;
        rst_n = 1'b0;
        req0_i[0] = 1'b0;
        #1;
        chk_zero("async_rst", 0);
        chk_zero("async_rst", 1);
        rv_before = rv_cnt0;
        repeat (2) @(posedge clock); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clock); #1;
        chk("no_rvalid_after_rst", 0, rv_cnt0 - rv_before, 0);
        lat_read(0, 10'h155, gl, rl, dat);
        chk("post_rst_rvalid_lat", 0, rl, 4);
        chk("post_rst_data",       0, 32'(dat), 32'hA5);

        // randomized traffic on all four ports
        fork
            rand_traffic(0, 0, 60);
            rand_traffic(0, 1, 60);
            rand_traffic(1, 0, 60);
            rand_traffic(1, 1, 60);
        join
        repeat (10) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
